// File: rtl/fpdiv.sv
// Multi-cycle binary32 divider: operands captured after reset release, 26-step restoring
// mantissa division, round-to-nearest-even, result held with DONE until the next reset.
module fpdiv (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] InputA,
    input  logic [31:0] InputB,
    output logic [31:0] AbyB,
    output logic        DONE,
    output logic [1:0]  EXCEPTION
);

    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam logic [1:0]  EXC_NONE  = 2'b00;
    localparam logic [1:0]  EXC_DIVZ  = 2'b01;
    localparam logic [1:0]  EXC_INV   = 2'b10;
    localparam logic [1:0]  EXC_RANGE = 2'b11;
    localparam logic [4:0]  LAST_ITER = 5'd25;

    typedef enum logic [1:0] {StLoad, StDivide, StFinish, StHold} state_e;

    state_e state_q, state_d;

    // Operand fields and classification, only meaningful in StLoad
    logic        sign_a, sign_b, res_sign;
    logic [7:0]  exp_a, exp_b;
    logic [22:0] frac_a, frac_b;
    logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

    assign sign_a   = InputA[31];
    assign sign_b   = InputB[31];
    assign exp_a    = InputA[30:23];
    assign exp_b    = InputB[30:23];
    assign frac_a   = InputA[22:0];
    assign frac_b   = InputB[22:0];
    assign res_sign = sign_a ^ sign_b;

    // Exponent 0 covers both zero and denormals, which are flushed to zero
    assign zero_a = (exp_a == 8'd0);
    assign zero_b = (exp_b == 8'd0);
    assign inf_a  = (exp_a == 8'hFF) && (frac_a == 23'd0);
    assign inf_b  = (exp_b == 8'hFF) && (frac_b == 23'd0);
    assign nan_a  = (exp_a == 8'hFF) && (frac_a != 23'd0);
    assign nan_b  = (exp_b == 8'hFF) && (frac_b != 23'd0);

    logic        special;
    logic [31:0] special_res;
    logic [1:0]  special_exc;

    always_comb begin
        special     = 1'b1;
        special_res = QNAN;
        special_exc = EXC_INV;
        if (nan_a || nan_b || (inf_a && inf_b) || (zero_a && zero_b)) begin
            special_res = QNAN;
            special_exc = EXC_INV;
        end else if (inf_a) begin
            special_res = {res_sign, 8'hFF, 23'd0};
            special_exc = EXC_NONE;
        end else if (zero_b) begin
            special_res = {res_sign, 8'hFF, 23'd0};
            special_exc = EXC_DIVZ;
        end else if (inf_b || zero_a) begin
            special_res = {res_sign, 31'd0};
            special_exc = EXC_NONE;
        end else begin
            special = 1'b0;
        end
    end

    // Datapath state
    logic              sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic [23:0]       mb_q, mb_d;
    logic [25:0]       rem_q, rem_d;
    logic [25:0]       quo_q, quo_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              special_q, special_d;
    logic [31:0]       spec_res_q, spec_res_d;
    logic [1:0]        spec_exc_q, spec_exc_d;
    logic [31:0]       res_q, res_d;
    logic [1:0]        exc_q, exc_d;
    logic              done_q, done_d;

    // One restoring-division step
    logic        rem_ge;
    logic [25:0] rem_sub;
    logic [25:0] rem_step;
    logic [25:0] quo_step;

    assign rem_ge   = rem_q >= {2'b00, mb_q};
    assign rem_sub  = rem_q - {2'b00, mb_q};
    assign rem_step = {(rem_ge ? rem_sub[24:0] : rem_q[24:0]), 1'b0};
    assign quo_step = {quo_q[24:0], rem_ge};

    // Normalize, round, range-check and pack
    logic              sticky, guard, rnd, round_up;
    logic [23:0]       mant_pre;
    logic [24:0]       mant_sum;
    logic [22:0]       frac_fin;
    logic signed [9:0] exp_pre, exp_fin;
    logic [31:0]       norm_res;
    logic [1:0]        norm_exc;

    always_comb begin
        sticky = |rem_q;
        if (quo_q[25]) begin
            mant_pre = quo_q[25:2];
            guard    = quo_q[1];
            rnd      = quo_q[0];
            exp_pre  = exp_q;
        end else begin
            mant_pre = quo_q[24:1];
            guard    = quo_q[0];
            rnd      = 1'b0;
            exp_pre  = exp_q - 10'sd1;
        end
        round_up = guard & (rnd | sticky | mant_pre[0]);
        mant_sum = {1'b0, mant_pre} + {24'd0, round_up};
        // Carry-out only happens from all-ones, so the shifted fraction is zero
        if (mant_sum[24]) begin
            frac_fin = mant_sum[23:1];
            exp_fin  = exp_pre + 10'sd1;
        end else begin
            frac_fin = mant_sum[22:0];
            exp_fin  = exp_pre;
        end
        if (exp_fin >= 10'sd255) begin
            norm_res = {sign_q, 8'hFF, 23'd0};
            norm_exc = EXC_RANGE;
        end else if (exp_fin <= 10'sd0) begin
            norm_res = {sign_q, 31'd0};
            norm_exc = EXC_RANGE;
        end else begin
            norm_res = {sign_q, exp_fin[7:0], frac_fin};
            norm_exc = EXC_NONE;
        end
    end

    // FSM: state register
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:   state_d = special ? StFinish : StDivide;
            StDivide: if (cnt_q == LAST_ITER) state_d = StFinish;
            StFinish: state_d = StHold;
            StHold:   state_d = StHold;
        endcase
    end

    // Datapath next state
    always_comb begin
        sign_d     = sign_q;
        exp_d      = exp_q;
        mb_d       = mb_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        spec_exc_d = spec_exc_q;
        res_d      = res_q;
        exc_d      = exc_q;
        done_d     = done_q;
        unique case (state_q)
            StLoad: begin
                sign_d     = res_sign;
                exp_d      = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'sd127;
                mb_d       = {1'b1, frac_b};
                rem_d      = {2'b00, 1'b1, frac_a};
                quo_d      = '0;
                cnt_d      = '0;
                special_d  = special;
                spec_res_d = special_res;
                spec_exc_d = special_exc;
            end
            StDivide: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 5'd1;
            end
            StFinish: begin
                res_d  = special_q ? spec_res_q : norm_res;
                exc_d  = special_q ? spec_exc_q : norm_exc;
                done_d = 1'b1;
            end
            StHold: begin
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mb_q       <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            spec_exc_q <= '0;
            res_q      <= '0;
            exc_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            mb_q       <= mb_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            spec_exc_q <= spec_exc_d;
            res_q      <= res_d;
            exc_q      <= exc_d;
            done_q     <= done_d;
        end
    end

    // FSM: outputs, all registered so they change together
    always_comb begin
        AbyB      = res_q;
        DONE      = done_q;
        EXCEPTION = exc_q;
    end

endmodule

// File: tb/tb_fpdiv.sv
// Bench for fpdiv: directed vector table, reset-abort and hold sequences, and random
// operands checked against an exact-remainder rounding model.
module tb_fpdiv;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] InputA = '0;
    logic [31:0] InputB = '0;
    logic [31:0] AbyB;
    logic        DONE;
    logic [1:0]  EXCEPTION;

    int tests  = 0;
    int failed = 0;

    fpdiv dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .InputA    (InputA),
        .InputB    (InputB),
        .AbyB      (AbyB),
        .DONE      (DONE),
        .EXCEPTION (EXCEPTION)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [1:0]  exc;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reset, load operands, release, and count edges until DONE (bounded)
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic [1:0] x, output int lat);
        RESET = 1'b0;
        @(negedge CLOCK);
        InputA = a;
        InputB = b;
        @(negedge CLOCK);
        RESET = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLOCK);
            #1;
            if (DONE === 1'b1) begin
                lat = i;
                break;
            end
        end
        r = AbyB;
        x = EXCEPTION;
    endtask

    // Exact quotient scaled to 24 significant bits; rounding decided from the remainder
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [1:0] x, output int lat);
        int     ea, eb, e, sh;
        longint ma, mb, num, q, rm;
        logic   s, za, zb, ia, ib, na, nb;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 23'd0);
        ib = (eb == 255) && (b[22:0] == 23'd0);
        na = (ea == 255) && (a[22:0] != 23'd0);
        nb = (eb == 255) && (b[22:0] != 23'd0);
        lat = 2;
        x   = 2'b00;
        if (na || nb || (ia && ib) || (za && zb)) begin
            r = 32'h7FC0_0000;
            x = 2'b10;
        end else if (ia) begin
            r = {s, 8'hFF, 23'd0};
        end else if (zb) begin
            r = {s, 8'hFF, 23'd0};
            x = 2'b01;
        end else if (ib || za) begin
            r = {s, 31'd0};
        end else begin
            lat = 28;
            ma  = longint'({1'b1, a[22:0]});
            mb  = longint'({1'b1, b[22:0]});
            sh  = (ma < mb) ? 1 : 0;
            num = ma << (23 + sh);
            q   = num / mb;
            rm  = num % mb;
            if ((2 * rm > mb) || ((2 * rm == mb) && (q % 2 == 1))) q = q + 1;
            e = ea - eb + 127 - sh;
            if (q == 64'd16777216) begin
                q = 64'd8388608;
                e = e + 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0};
                x = 2'b11;
            end else if (e <= 0) begin
                r = {s, 31'd0};
                x = 2'b11;
            end else begin
                r = {s, 8'(e), 23'(q)};
            end
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [7:0]  e;
        logic [22:0] f;
        f = 23'($urandom);
        case ($urandom_range(0, 9))
            0:       e = 8'd0;
            1:       e = 8'hFF;
            2, 3:    e = 8'($urandom_range(1, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        if ((e == 8'hFF) && ($urandom_range(0, 1) == 0)) f = 23'd0;
        return {1'($urandom), e, f};
    endfunction

    initial begin
        logic [31:0] r, er;
        logic [1:0]  x, ex;
        int          lat, elat;
        logic [31:0] a, b;

        vecs.push_back('{32'h4080_0000, 32'h0000_0000, 32'h7F80_0000, 2'b01, 2});
        vecs.push_back('{32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 2'b00, 28});
        vecs.push_back('{32'h4119_999A, 32'h4099_999A, 32'h4000_0000, 2'b00, 28});
        vecs.push_back('{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 2'b10, 2});
        vecs.push_back('{32'h7F80_0001, 32'h4099_999A, 32'h7FC0_0000, 2'b10, 2});
        vecs.push_back('{32'h6F99_999A, 32'h0099_999A, 32'h7F80_0000, 2'b11, 28});
        vecs.push_back('{32'h0099_999A, 32'h6F99_999A, 32'h0000_0000, 2'b11, 28});
        vecs.push_back('{32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 2'b00, 28});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 2'b10, 2});
        vecs.push_back('{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 2'b00, 2});
        vecs.push_back('{32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 2'b00, 2});
        vecs.push_back('{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 2'b00, 2});
        vecs.push_back('{32'hC080_0000, 32'h8000_0000, 32'h7F80_0000, 2'b01, 2});
        vecs.push_back('{32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 2'b00, 2});
        vecs.push_back('{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 2'b00, 28});

        #2 RESET = 1'b0;
        #1;
        check("reset AbyB", AbyB, 32'd0);
        check("reset DONE", 32'(DONE), 32'd0);
        check("reset EXCEPTION", 32'(EXCEPTION), 32'd0);

        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, r, x, lat);
            check($sformatf("vec%0d AbyB", i), r, vecs[i].res);
            check($sformatf("vec%0d EXCEPTION", i), 32'(x), 32'(vecs[i].exc));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Result must stay frozen while inputs wander
        InputA = 32'h4080_0000;
        InputB = 32'h0000_0000;
        repeat (5) @(posedge CLOCK);
        #1;
        check("hold AbyB", AbyB, 32'h3EAA_AAAB);
        check("hold EXCEPTION", 32'(EXCEPTION), 32'd0);
        check("hold DONE", 32'(DONE), 32'd1);

        // Abort 1.0/3.0 mid-divide, then rerun
        RESET = 1'b0;
        @(negedge CLOCK);
        InputA = 32'h3F80_0000;
        InputB = 32'h4040_0000;
        @(negedge CLOCK);
        RESET = 1'b1;
        repeat (10) @(posedge CLOCK);
        #1;
        check("abort DONE before reset", 32'(DONE), 32'd0);
        check("abort AbyB before reset", AbyB, 32'd0);
        #2 RESET = 1'b0;
        #1;
        check("abort AbyB", AbyB, 32'd0);
        check("abort DONE", 32'(DONE), 32'd0);
        check("abort EXCEPTION", 32'(EXCEPTION), 32'd0);
        @(posedge CLOCK);
        #1;
        check("abort DONE held", 32'(DONE), 32'd0);
        run_div(32'h3F80_0000, 32'h4040_0000, r, x, lat);
        check("rerun AbyB", r, 32'h3EAA_AAAB);
        check("rerun EXCEPTION", 32'(x), 32'd0);
        check("rerun latency", 32'(lat), 32'd28);

        for (int n = 0; n < 80; n++) begin
            a = rand_operand();
            b = rand_operand();
            model(a, b, er, ex, elat);
            run_div(a, b, r, x, lat);
            check($sformatf("rand%0d %h/%h AbyB", n, a, b), r, er);
            check($sformatf("rand%0d %h/%h EXCEPTION", n, a, b), 32'(x), 32'(ex));
            check($sformatf("rand%0d %h/%h latency", n, a, b), 32'(lat), 32'(elat));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fpdiv.md
# fpdiv

Multi-cycle IEEE-754 single-precision floating-point divider computing AbyB = InputA / InputB. Operands are captured once after reset is released. The mantissa quotient is produced by a bit-serial restoring divider with guard/round/sticky bits. The result is rounded to nearest-even and held with DONE until the next reset. It is a standalone arithmetic block: a host loads operands under reset, releases reset, and polls DONE.

## Interface
- No parameters; format fixed at binary32 (1 sign, 8 exponent bias 127, 23 fraction).
- One clock; reset is asynchronous and active-low.
- CLOCK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
  - Low: aborts any operation and clears state.
  - Release (high): starts a new division.
- InputA  input  32  dividend, binary32.
- InputB  input  32  divisor, binary32.
- AbyB  output  32  quotient, binary32; valid when DONE=1.
- DONE  output  1  result valid; held until reset.
- EXCEPTION  output  2  status, valid when DONE=1:
  - 00 none
  - 01 divide-by-zero
  - 10 invalid (NaN result)
  - 11 overflow or underflow

## Operation
- States: LOAD → DIVIDE → FINISH → HOLD. Reset forces LOAD.
- LOAD: register sign, exponent and mantissa of both inputs; classify operands.
  - Exponent 0 is treated as zero; denormals are flushed.
  - Exponent 255 with fraction 0 is Inf; exponent 255 with fraction ≠0 is NaN.
- Special cases skip DIVIDE (sign = sA^sB unless NaN):
  - Either NaN, Inf/Inf, or 0/0 → 0x7FC00000, EXC=10.
  - finite nonzero / 0 → ±Inf, EXC=01.
  - Inf / finite (including 0) → ±Inf, EXC=00.
  - finite / Inf, or 0 / finite nonzero → ±0, EXC=00.
- Normal path:
  - mA = {1,fracA}, mB = {1,fracB} (24 bits).
  - Biased exponent E = eA − eB + 127, 10-bit signed.
  - DIVIDE: 26 iterations of restoring division, one quotient bit per cycle, MSB first. This gives q = floor(mA·2^25 / mB); remainder R ≠ 0 sets sticky S.
  - If q[25]=1: mantissa q[25:2], guard G=q[1], round Rd=q[0].
  - Else: mantissa q[24:1], G=q[0], Rd=0, E=E−1.
  - Rounding (round-to-nearest-even): increment when G & (Rd | S | mantissa LSB). On mantissa carry-out, shift right and E=E+1.
  - E ≥ 255 → ±Inf (0x7F800000 with sign), EXC=11.
  - E ≤ 0 → ±0, EXC=11 (flush, no denormal output).
  - Otherwise pack {sign, E[7:0], mantissa[22:0]}, EXC=00.
- HOLD: outputs frozen. Input changes after LOAD are ignored.

## Timing
- While RESET=0 (asynchronous):
  - AbyB=0, DONE=0, EXCEPTION=00.
  - State = LOAD, divider registers cleared.
- Edge 1 after release: LOAD samples InputA/InputB. Inputs must be stable from release through edge 1.
- Special case: AbyB/EXCEPTION written and DONE=1 on edge 2.
- Normal case:
  - Edges 2–27 are the 26 DIVIDE iterations.
  - Edge 28 is FINISH (normalize, round, range check, pack); DONE=1 after edge 28.
- DONE, AbyB and EXCEPTION change together in the same edge. DONE stays 1 until RESET goes low.
- Reset asserted mid-DIVIDE: immediate abort, outputs cleared. No partial result appears on AbyB.
- No new operation starts without a reset pulse.

## Test plan
- 4.0 (0x40800000) / 0.0 → AbyB=0x7F800000, EXC=01, DONE at edge 2.
- 4.0 / 2.0 (0x40000000) → 0x40000000, EXC=00, DONE at edge 28.
- 9.6 (0x4119999A) / 4.8 (0x4099999A) → 0x40000000 exact, EXC=00.
- Inf/Inf (0x7F800000 both) → 0x7FC00000, EXC=10; NaN 0x7F800001 / 4.8 → 0x7FC00000, EXC=10.
- 0x6F99999A / 0x0099999A → 0x7F800000, EXC=11. Swapped operands → 0x00000000, EXC=11.
- Reset pulse at edge 10 of 1.0/3.0, then rerun → outputs 0 during reset; rerun gives 0x3EAAAAAB.
  - Also check −6.0/2.0 → 0xC0400000.
